gcd_stim_driver: RTL and testbench
==================================

// Module: gcd_stim_driver
// PURPOSE
//   Initiator side of the GCD engine operand interface: generates operand pairs from an LFSR,
//   pulses load with a/b, waits for the engine's done, captures the result and folds it into a signature.
//   Sits between the top-level test/control logic and one GCD engine instance.
//   Provides self-test and throughput measurement for the GCD datapath.
// PARAMETERS
//   WIDTH    7        operand/result width (matches the GCD engine)
//   TIMEOUT  63       max cycles to wait for gcd_done before declaring an error (1..255)
//   SEED     14'h2A5  non-zero LFSR reset value, 2*WIDTH bits
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        synchronous active-low reset
//   start       in   1        begin a run; sampled only in IDLE
//   num_ops     in   8        operand pairs per run; sampled with start
//   load        out  1        one-cycle load strobe to the engine
//   a           out  WIDTH    operand A to the engine; valid while load=1
//   b           out  WIDTH    operand B to the engine; valid while load=1
//   gcd_c       in   WIDTH    engine result; valid when gcd_done=1
//   gcd_done    in   1        engine completion pulse
//   busy        out  1        run in progress
//   run_done    out  1        one-cycle pulse at run end
//   signature   out  2*WIDTH  rotate-XOR signature of captured results
//   ops_done    out  8        pairs completed in the current/last run
//   err_count   out  8        timeouts plus zero results, saturating at 8'hFF
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): state=IDLE; load=0; a=b=0; busy=0; run_done=0; signature=0;
//     ops_done=0; err_count=0; lfsr=SEED.
//   - rst_n has priority over every other input, including in mid-run; no partial result survives.
//   - LFSR: 2*WIDTH-bit Fibonacci, taps x^14+x^13+x^12+x^2+1 (WIDTH=7); steps once per LOAD.
//   - Operands: a=lfsr[2W-1:W], b=lfsr[W-1:0]; any zero field is replaced by 1, so the engine never gets 0.
//   - FSM:
//     IDLE:    start=1 and num_ops!=0 -> LOAD; clear signature/ops_done/err_count; latch num_ops.
//              start=1 and num_ops==0 -> DONE; counters cleared, nothing issued.
//     LOAD:    load=1 for exactly one cycle with a/b driven; step lfsr; clear wait counter -> WAIT.
//     WAIT:    gcd_done=1 -> CAPTURE; wait counter reaches TIMEOUT -> CAPTURE flagged timeout.
//              gcd_done in the cycle the counter reaches TIMEOUT counts as done, not as timeout.
//     CAPTURE: timeout -> err_count+1, signature unchanged; otherwise
//              signature={signature[2W-2:0],signature[2W-1]} ^ {W'b0,gcd_c}; gcd_c==0 -> err_count+1.
//              ops_done+1; ops_done==latched num_ops -> DONE, else -> LOAD.
//     DONE:    run_done=1 for one cycle -> IDLE.
//   - busy=1 in LOAD, WAIT, CAPTURE and DONE; 0 in IDLE.
//   - gcd_done outside WAIT is ignored. start outside IDLE is ignored.
//   - load→engine latency: engine samples a/b on the clk edge where load=1.
//   - Minimum per-pair cost: 3 cycles (LOAD, WAIT with gcd_done, CAPTURE).
//   - Counters are 8-bit; err_count saturates; ops_done cannot overflow (bounded by num_ops).
//   - outputs a/b hold their last values after LOAD; they are don't-care to the engine.
// STRUCTURE
//   - Shared package: state encoding (IDLE/LOAD/WAIT/CAPTURE/DONE), LFSR tap mask, GCD WIDTH constant.
//   - One sub-module: gcd_lfsr (step enable, seed load, zero-field substitution on outputs).
//   - FSM, wait counter and signature/counter registers stay in the top module.
// TESTING
//   - Reset mid-WAIT, rst_n=0 for 1 cycle -> next cycle: busy=0, load=0, signature=0, err_count=0, lfsr=SEED.
//   - start, num_ops=0 -> run_done pulses 2 cycles later, load never asserted, ops_done=0.
//   - start, num_ops=1, model answers gcd_c=7'd5 two cycles after load -> signature=14'h0005, ops_done=1, err_count=0.
//   - start, num_ops=3, model never asserts gcd_done -> each wait ends after TIMEOUT=63 cycles; err_count=3, signature=0.
//   - start, num_ops=4, behavioural Stein model -> a/b match golden LFSR sequence and signature matches reference fold.
//   - gcd_done and timeout in the same cycle, gcd_c=7'd1 -> counted as success: err_count=0, signature=14'h0001.

Source files
------------

// File: rtl/gcd_stim_driver_pkg.sv
// Shared constants and types for the GCD operand stimulus driver.
package gcd_stim_driver_pkg;

  localparam int unsigned GCD_WIDTH  = 7;
  localparam int unsigned LFSR_WIDTH = 2 * GCD_WIDTH;

  // x^14 + x^13 + x^12 + x^2 + 1 -> feedback from bits 13, 12, 11, 1
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 14'h3802;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gcd_lfsr.sv
// Fibonacci LFSR producing a non-zero operand pair; steps on demand, reseeds on reset.
module gcd_lfsr
  import gcd_stim_driver_pkg::*;
#(
  parameter int unsigned           WIDTH = GCD_WIDTH,
  parameter logic [2*WIDTH-1:0]    SEED  = (2*WIDTH)'(14'h2A5)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [WIDTH-1:0] a_c,
  output logic [WIDTH-1:0] b_c
);

  localparam int unsigned     LW   = 2 * WIDTH;
  localparam logic [LW-1:0]   TAPS = LW'(LFSR_TAPS);

  logic [LW-1:0]    state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[LW-2:0], ^(state & TAPS)};
    end
  end

  assign hi = state[LW-1:WIDTH];
  assign lo = state[WIDTH-1:0];

  // The engine must never see a zero operand.
  assign a_c = (hi == '0) ? WIDTH'(1) : hi;
  assign b_c = (lo == '0) ? WIDTH'(1) : lo;

endmodule

// File: rtl/gcd_stim_driver.sv
// Drives LFSR operand pairs into a GCD engine, waits for each result and folds it into a signature.
module gcd_stim_driver
  import gcd_stim_driver_pkg::*;
#(
  parameter int unsigned        WIDTH   = GCD_WIDTH,
  parameter int unsigned        TIMEOUT = 63,
  parameter logic [2*WIDTH-1:0] SEED    = (2*WIDTH)'(14'h2A5)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         num_ops,
  output logic               load,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   gcd_c,
  input  logic               gcd_done,
  output logic               busy,
  output logic               run_done,
  output logic [2*WIDTH-1:0] signature,
  output logic [7:0]         ops_done,
  output logic [7:0]         err_count
);

  state_t           state;
  logic [7:0]       num_ops_q;
  logic [7:0]       wait_cnt;
  logic [WIDTH-1:0] result_q;
  logic             timeout_q;
  logic             lfsr_step;
  logic [WIDTH-1:0] lfsr_a;
  logic [WIDTH-1:0] lfsr_b;
  logic [7:0]       ops_next;

  assign lfsr_step = (state == S_LOAD);
  assign ops_next  = ops_done + 8'd1;

  gcd_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .a_c   (lfsr_a),
    .b_c   (lfsr_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      load      <= 1'b0;
      a         <= '0;
      b         <= '0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
      signature <= '0;
      ops_done  <= 8'd0;
      err_count <= 8'd0;
      num_ops_q <= 8'd0;
      wait_cnt  <= 8'd0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      load     <= 1'b0;
      run_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            signature <= '0;
            ops_done  <= 8'd0;
            err_count <= 8'd0;
            num_ops_q <= num_ops;
            busy      <= 1'b1;
            if (num_ops != 8'd0) begin
              state <= S_LOAD;
              load  <= 1'b1;
              a     <= lfsr_a;
              b     <= lfsr_b;
            end else begin
              state    <= S_DONE;
              run_done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          wait_cnt <= 8'd0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the final wait cycle wins over the timeout.
          if (gcd_done) begin
            result_q  <= gcd_c;
            timeout_q <= 1'b0;
            state     <= S_CAPTURE;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state     <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_CAPTURE: begin
          if (timeout_q) begin
            err_count <= sat_inc8(err_count);
          end else begin
            signature <= {signature[2*WIDTH-2:0], signature[2*WIDTH-1]}
                         ^ {WIDTH'(0), result_q};
            if (result_q == '0) begin
              err_count <= sat_inc8(err_count);
            end
          end
          ops_done <= ops_next;
          if (ops_next == num_ops_q) begin
            state    <= S_DONE;
            run_done <= 1'b1;
          end else begin
            state <= S_LOAD;
            load  <= 1'b1;
            a     <= lfsr_a;
            b     <= lfsr_b;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stim_driver.sv
// Self-checking bench for gcd_stim_driver: engine model, golden LFSR and signature fold in plain arithmetic.
module tb_gcd_stim_driver;

  localparam int unsigned W    = 7;
  localparam int unsigned TMO  = 63;
  localparam logic [13:0] SEED_V = 14'h2A5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   num_ops;
  logic         load;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] gcd_c;
  logic         gcd_done;
  logic         busy;
  logic         run_done;
  logic [13:0]  signature;
  logic [7:0]   ops_done;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;
  logic [13:0] lfsr_m;

  always #5 clk = ~clk;

  gcd_stim_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_ops   (num_ops),
    .load      (load),
    .a         (a),
    .b         (b),
    .gcd_c     (gcd_c),
    .gcd_done  (gcd_done),
    .busy      (busy),
    .run_done  (run_done),
    .signature (signature),
    .ops_done  (ops_done),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Polynomial x^14+x^13+x^12+x^2+1, new bit enters at the bottom.
  function automatic logic [13:0] lfsr_next(input logic [13:0] s);
    return {s[12:0], s[13] ^ s[12] ^ s[11] ^ s[1]};
  endfunction

  function automatic logic [6:0] nz(input logic [6:0] v);
    return (v == 7'd0) ? 7'd1 : v;
  endfunction

  function automatic int stein(input int x_in, input int y_in);
    int x = x_in;
    int y = y_in;
    int k = 0;
    int t;
    if (x == 0) return y;
    if (y == 0) return x;
    while (((x | y) & 1) == 0) begin x = x >> 1; y = y >> 1; k++; end
    while ((x & 1) == 0) x = x >> 1;
    while (y != 0) begin
      while ((y & 1) == 0) y = y >> 1;
      if (x > y) begin t = x; x = y; y = t; end
      y = y - x;
    end
    return x << k;
  endfunction

  // mode 0: Stein answers after random delay; 1: fixed value after fixed delay; 2: never answers
  task automatic run(input int n, input int mode, input int fixed_val, input int fixed_delay,
                     input string tag);
    logic [13:0] sig_m = 14'd0;
    int err_m = 0;
    int loads = 0;
    int pend = 0;
    int last_load = -1;
    int exp_gap = 0;
    int cyc = 0;
    int dly;
    bit got = 0;
    logic [6:0] ea;
    logic [6:0] eb;
    logic [6:0] resp = 7'd0;

    start   = 1'b1;
    num_ops = n[7:0];
    for (int c = 1; c <= 6000; c++) begin
      step();
      cyc = c;
      start    = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      num_ops  = 8'($urandom);
      gcd_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          gcd_done = 1'b1;
          gcd_c    = resp;
          sig_m    = {sig_m[12:0], sig_m[13]} ^ {7'd0, resp};
          if (resp == 7'd0) err_m++;
        end
      end
      if (load) begin
        ea = nz(lfsr_m[13:7]);
        eb = nz(lfsr_m[6:0]);
        chk({tag, "_a"}, 32'(a), 32'(ea));
        chk({tag, "_b"}, 32'(b), 32'(eb));
        if (last_load >= 0) chk({tag, "_gap"}, 32'(c - last_load), 32'(exp_gap));
        lfsr_m    = lfsr_next(lfsr_m);
        loads++;
        last_load = c;
        case (mode)
          0:       begin dly = $urandom_range(1, 8); resp = 7'(stein(int'(ea), int'(eb))); end
          1:       begin dly = fixed_delay; resp = 7'(fixed_val); end
          default: begin dly = 0; err_m++; end
        endcase
        pend    = dly;
        exp_gap = (dly == 0) ? int'(TMO) + 2 : dly + 2;
      end
      if (run_done) begin
        start = 1'b0;
        got   = 1'b1;
        break;
      end
    end
    gcd_done = 1'b0;
    chk({tag, "_run_done_seen"}, 32'(got), 32'd1);
    if (n == 0) chk({tag, "_done_latency_le2"}, 32'(cyc <= 2), 32'd1);
    else        chk({tag, "_last_gap"}, 32'(cyc - last_load), 32'(exp_gap));
    chk({tag, "_loads"},     32'(loads),     32'(n));
    chk({tag, "_signature"}, 32'(signature), 32'(sig_m));
    chk({tag, "_ops_done"},  32'(ops_done),  32'(n));
    chk({tag, "_err_count"}, 32'(err_count), 32'((err_m > 255) ? 255 : err_m));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_busy_after"},  32'(busy),     32'd0);
    chk({tag, "_pulse_once"},  32'(run_done), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    num_ops  = 8'd0;
    gcd_done = 1'b0;
    gcd_c    = '0;
    repeat (2) step();
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_load",      32'(load),      32'd0);
    chk("rst_a",         32'(a),         32'd0);
    chk("rst_b",         32'(b),         32'd0);
    chk("rst_run_done",  32'(run_done),  32'd0);
    chk("rst_signature", 32'(signature), 32'd0);
    chk("rst_ops_done",  32'(ops_done),  32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n  = 1'b1;
    lfsr_m = SEED_V;
    step();

    run(0, 1, 0, 1, "zero_ops");
    run(1, 1, 5, 2, "single_5");
    chk("single_5_sig_const", 32'(signature), 32'h0005);
    run(3, 2, 0, 0, "timeouts");
    run(4, 0, 0, 0, "stein4");
    run(1, 1, 1, int'(TMO), "edge_done");
    chk("edge_done_sig_const", 32'(signature), 32'h0001);
    run(2, 1, 0, 1, "zero_result");
    run($urandom_range(5, 12), 0, 0, 0, "stein_rand");

    // Reset in the middle of the second wait of a timing-out run.
    start   = 1'b1;
    num_ops = 8'd3;
    step();
    start = 1'b0;
    repeat (74) step();
    chk("pre_rst_busy", 32'(busy),      32'd1);
    chk("pre_rst_err",  32'(err_count), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_load",      32'(load),      32'd0);
    chk("mid_rst_signature", 32'(signature), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_ops_done",  32'(ops_done),  32'd0);
    lfsr_m = SEED_V;
    step();
    run(2, 0, 0, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
